// File: rtl/player_missile.sv
// player_missile: single player shot, launched from the ship and stepped upward once per frame.
// Optional PLAYER_MISSILE_AUTOFIRE_EN: fire level (not edge) launches from IDLE.
module player_missile #(
  parameter int NUM_ALIENS   = 8,
  parameter int MISSILE_STEP = 4,
  parameter int MISSILE_W    = 3,
  parameter int MISSILE_H    = 6,
  parameter int SHIP_W       = 25,
  parameter int Y_MIN        = 0,
  parameter int PARK_X       = 1000,
  parameter int PARK_Y       = 1000
) (
  input  logic                  frame_clk,
  input  logic                  Reset_n,
  input  logic                  fire,
  input  logic [9:0]            ShipX,
  input  logic [9:0]            ShipY,
  input  logic [NUM_ALIENS-1:0] hit_vec,
  output logic [9:0]            PlayerMissileX,
  output logic [9:0]            PlayerMissileY,
  output logic [9:0]            PlayerMissileS,
  output logic                  active,
  output logic [7:0]            shots,
  output logic [7:0]            hits
);
  typedef enum logic [1:0] {IDLE, LAUNCH, FLY, RETIRE} state_t;
  localparam logic [9:0] X_OFF = 10'(SHIP_W / 2 - 1);
  localparam logic [9:0] Y_LIM = 10'(Y_MIN + MISSILE_STEP);
  localparam logic [9:0] PX    = 10'(PARK_X);
  localparam logic [9:0] PY    = 10'(PARK_Y);
  state_t state, state_nx;
  logic [9:0] x_nx, y_nx;
  logic [7:0] shots_nx, hits_nx;
  logic fire_prev, fire_req, any_hit;
  logic [NUM_ALIENS-1:0] hit_prev;
`ifdef PLAYER_MISSILE_AUTOFIRE_EN
  assign fire_req = fire;
`else
  assign fire_req = fire & ~fire_prev;
`endif
  // only rising hit bits count; a cleared alien flag is not an event
  assign any_hit = |(hit_vec & ~hit_prev);
  assign PlayerMissileS = 10'(MISSILE_W);
  always_comb begin
    state_nx = state;
    x_nx = PlayerMissileX;
    y_nx = PlayerMissileY;
    shots_nx = shots;
    hits_nx = hits;
    unique case (state)
      IDLE: begin
        x_nx = PX;
        y_nx = PY;
        state_nx = fire_req ? LAUNCH : IDLE;
      end
      LAUNCH: begin
        x_nx = ShipX + X_OFF;
        y_nx = ShipY - 10'(MISSILE_H);
        shots_nx = shots + {7'd0, shots != 8'hFF};
        state_nx = FLY;
      end
      FLY: begin
        if (any_hit || PlayerMissileY < Y_LIM) begin
          x_nx = PX;
          y_nx = PY;
          state_nx = RETIRE;
          hits_nx = any_hit ? hits + {7'd0, hits != 8'hFF} : hits;
        end else
          y_nx = PlayerMissileY - 10'(MISSILE_STEP);
      end
      RETIRE: begin
        x_nx = PX;
        y_nx = PY;
        state_nx = IDLE;
      end
    endcase
  end
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      PlayerMissileX <= PX;
      PlayerMissileY <= PY;
      active <= 1'b0;
      shots <= 8'd0;
      hits <= 8'd0;
      fire_prev <= 1'b0;
      hit_prev <= '0;
    end else begin
      state <= state_nx;
      PlayerMissileX <= x_nx;
      PlayerMissileY <= y_nx;
      active <= state_nx == LAUNCH || state_nx == FLY;
      shots <= shots_nx;
      hits <= hits_nx;
      fire_prev <= fire;
      hit_prev <= hit_vec;
    end
  end
endmodule
